// File: rtl/steer_demux_pkg.sv
// Shared types for the steering demux: FSM encoding, register bundle and select-width helper.
package steer_demux_pkg;

  typedef enum logic {
    ST_ROUTE = 1'b0,
    ST_DEAD  = 1'b1
  } steer_state_t;

  // Control registers kept in one bundle so checkers can bind to a single name.
  // cur/pend/cnt are 4 bits wide: enough for the 16-channel, 15-cycle maximum.
  typedef struct packed {
    steer_state_t state;
    logic [3:0]   cur;
    logic [3:0]   pend;
    logic [3:0]   cnt;
    logic         err;
  } steer_regs_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/steer_demux_slice.sv
// One registered output channel: follows/holds the signal when routed, otherwise shows its default.
module steer_demux_slice
  import steer_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             route,
  input  logic             dead,
  input  logic             en,
  input  logic [WIDTH-1:0] signal,
  input  logic [WIDTH-1:0] dflt,
  output logic [WIDTH-1:0] q,
  output logic             active
);

  logic live;
  assign live = route & ~dead;

  // While routed with en=0 the slice holds; after dead time that held value is the default.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      active <= 1'b0;
    end else begin
      active <= live;
      if (live) begin
        if (en) q <= signal;
      end else begin
        q <= dflt;
      end
    end
  end

endmodule

// File: rtl/steer_demux.sv
// N-channel registered steering demux with break-before-make dead time on select changes.
module steer_demux
  import steer_demux_pkg::*;
#(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  parameter  int DEAD     = 1,
  localparam int SELW     = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SELW-1:0]           sel,
  input  logic                      sel_load,
  input  logic                      en,
  input  logic [WIDTH-1:0]          signal,
  input  logic [CHANNELS*WIDTH-1:0] defaults,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       active,
  output logic                      busy,
  output logic                      err
);

  localparam logic [3:0]    DEAD_LOAD = 4'((DEAD == 0) ? 0 : DEAD - 1);
  localparam logic [SELW:0] CH_LIM    = (SELW + 1)'(CHANNELS);

  steer_regs_t st, st_d;
  logic        sel_ok;
  logic [3:0]  sel_x;
  logic [CHANNELS-1:0] route;
  logic        dead;
  logic        busy_d;
  logic [WIDTH-1:0] q_ch [CHANNELS];

  assign sel_ok = ({1'b0, sel} < CH_LIM);
  assign sel_x  = 4'(sel);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= '{state: ST_ROUTE, cur: 4'd0, pend: 4'd0, cnt: 4'd0, err: 1'b0};
      busy <= 1'b0;
    end else begin
      st   <= st_d;
      busy <= busy_d;
    end
  end

  // Next-state logic; a valid load during dead time restarts the countdown.
  always_comb begin
    st_d = st;
    if (sel_load && !sel_ok) st_d.err = 1'b1;
    case (st.state)
      ST_ROUTE: begin
        if (sel_load && sel_ok && (sel_x != st.cur)) begin
          if (DEAD == 0) begin
            st_d.cur = sel_x;
          end else begin
            st_d.pend  = sel_x;
            st_d.cnt   = DEAD_LOAD;
            st_d.state = ST_DEAD;
          end
        end
      end
      ST_DEAD: begin
        if (sel_load && sel_ok) begin
          st_d.pend = sel_x;
          st_d.cnt  = DEAD_LOAD;
        end else if (st.cnt == 4'd0) begin
          st_d.cur   = st.pend;
          st_d.state = ST_ROUTE;
        end else begin
          st_d.cnt = st.cnt - 4'd1;
        end
      end
      default: st_d.state = ST_ROUTE;
    endcase
  end

  // Output decode feeding the registered slices and busy flag
  always_comb begin
    dead   = (st.state == ST_DEAD);
    busy_d = dead;
    for (int k = 0; k < CHANNELS; k++) begin
      route[k] = (st.cur == 4'(k));
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slice
    steer_demux_slice #(.WIDTH(WIDTH)) u_slice (
      .clk    (clk),
      .rst    (rst),
      .route  (route[k]),
      .dead   (dead),
      .en     (en),
      .signal (signal),
      .dflt   (defaults[k*WIDTH +: WIDTH]),
      .q      (q_ch[k]),
      .active (active[k])
    );
  end

  always_comb begin
    q = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      q[k*WIDTH +: WIDTH] = q_ch[k];
    end
  end

  assign err = st.err;

endmodule

// File: tb/tb_steer_demux.sv
// Bench for steer_demux: three parameter variants driven together, checked against a cycle model.
module tb_steer_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        sel_load;
  logic        en;
  logic [7:0]  signal;
  logic [31:0] defs;

  logic [31:0] q_main, q_d0;
  logic [23:0] q_c3;
  logic [3:0]  act_main, act_d0;
  logic [2:0]  act_c3;
  logic        busy_main, busy_d0, busy_c3;
  logic        err_main, err_d0, err_c3;

  int tests = 0;
  int failed = 0;
  bit started = 0;

  always #5 clk = ~clk;

  steer_demux #(.WIDTH(8), .CHANNELS(4), .DEAD(2)) u_main (
    .clk(clk), .rst(rst), .sel(sel), .sel_load(sel_load), .en(en), .signal(signal),
    .defaults(defs), .q(q_main), .active(act_main), .busy(busy_main), .err(err_main));

  steer_demux #(.WIDTH(8), .CHANNELS(4), .DEAD(0)) u_d0 (
    .clk(clk), .rst(rst), .sel(sel), .sel_load(sel_load), .en(en), .signal(signal),
    .defaults(defs), .q(q_d0), .active(act_d0), .busy(busy_d0), .err(err_d0));

  steer_demux #(.WIDTH(8), .CHANNELS(3), .DEAD(1)) u_c3 (
    .clk(clk), .rst(rst), .sel(sel), .sel_load(sel_load), .en(en), .signal(signal),
    .defaults(defs[23:0]), .q(q_c3), .active(act_c3), .busy(busy_c3), .err(err_c3));

  // Behavioural model: per instance, channel values plus "dead cycles remaining".
  logic [7:0] m_q   [3][4];
  logic [3:0] m_act [3];
  logic       m_busy[3];
  logic       m_err [3];
  int         m_cur [3];
  int         m_pend[3];
  int         m_left[3];

  function automatic logic [7:0] def_of(input int k);
    return defs[k*8 +: 8];
  endfunction

  task automatic model_edge(input int i, input int ch, input int dd);
    bit valid;
    if (rst) begin
      for (int k = 0; k < 4; k++) m_q[i][k] = 8'h00;
      m_act[i] = 4'b0; m_busy[i] = 1'b0; m_err[i] = 1'b0;
      m_cur[i] = 0; m_pend[i] = 0; m_left[i] = 0;
      return;
    end
    if (m_left[i] > 0) begin
      for (int k = 0; k < ch; k++) m_q[i][k] = def_of(k);
      m_act[i] = 4'b0;
      m_busy[i] = 1'b1;
    end else begin
      for (int k = 0; k < ch; k++) begin
        if (k == m_cur[i]) begin
          if (en) m_q[i][k] = signal;
        end else begin
          m_q[i][k] = def_of(k);
        end
      end
      m_act[i] = 4'(1 << m_cur[i]);
      m_busy[i] = 1'b0;
    end
    valid = sel_load && (int'(sel) < ch);
    if (sel_load && !valid) m_err[i] = 1'b1;
    if (valid && (m_left[i] > 0 || int'(sel) != m_cur[i])) begin
      if (dd == 0) m_cur[i] = int'(sel);
      else begin
        m_pend[i] = int'(sel);
        m_left[i] = dd;
      end
    end else if (m_left[i] > 0) begin
      m_left[i]--;
      if (m_left[i] == 0) m_cur[i] = m_pend[i];
    end
  endtask

  function automatic logic [31:0] exp_q(input int i, input int ch);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < ch; k++) r[k*8 +: 8] = m_q[i][k];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, 4, 2);
    model_edge(1, 4, 0);
    model_edge(2, 3, 1);
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("main_q", q_main, exp_q(0, 4));
      check("main_active", 32'(act_main), 32'(m_act[0]));
      check("main_busy", 32'(busy_main), 32'(m_busy[0]));
      check("main_err", 32'(err_main), 32'(m_err[0]));
      check("d0_q", q_d0, exp_q(1, 4));
      check("d0_active", 32'(act_d0), 32'(m_act[1]));
      check("d0_busy", 32'(busy_d0), 32'(m_busy[1]));
      check("d0_err", 32'(err_d0), 32'(m_err[1]));
      check("c3_q", 32'(q_c3), exp_q(2, 3));
      check("c3_active", 32'(act_c3), 32'(m_act[2][2:0]));
      check("c3_busy", 32'(busy_c3), 32'(m_busy[2]));
      check("c3_err", 32'(err_c3), 32'(m_err[2]));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0; sel_load = 1'b0; en = 1'b1;
    signal = 8'h5A; defs = 32'hD3C2B1A0;
    step(); step();
    check("lit_reset_q", q_main, 32'h0);
    check("lit_reset_active", 32'(act_main), 32'h0);

    rst = 1'b0;
    step();
    check("lit_idle_q", q_main, 32'hD3C2B15A);
    check("lit_idle_active", 32'(act_main), 32'h1);
    check("lit_idle_busy", 32'(busy_main), 32'h0);

    en = 1'b0; signal = 8'hFF;
    step();
    check("lit_hold_q", q_main, 32'hD3C2B15A);
    en = 1'b1;
    step();
    check("lit_follow_q", q_main, 32'hD3C2B1FF);

    signal = 8'h5A; sel = 2'd2; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    check("lit_strobe_edge_busy", 32'(busy_main), 32'h0);
    step();
    check("lit_dead1_q", q_main, 32'hD3C2B1A0);
    check("lit_dead1_active", 32'(act_main), 32'h0);
    check("lit_dead1_busy", 32'(busy_main), 32'h1);
    check("lit_d0_switch", 32'(act_d0), 32'h4);
    step();
    check("lit_dead2_q", q_main, 32'hD3C2B1A0);
    step();
    check("lit_switched_q", q_main, 32'hD35AB1A0);
    check("lit_switched_active", 32'(act_main), 32'h4);
    check("lit_switched_busy", 32'(busy_main), 32'h0);

    sel = 2'd1; sel_load = 1'b1;
    step();
    sel = 2'd3;
    step();
    sel_load = 1'b0;
    check("lit_d0_ch1", 32'(act_d0), 32'h2);
    check("lit_restart_dead_q", q_main, 32'hD3C2B1A0);
    step(); step();
    check("lit_restart_busy", 32'(busy_main), 32'h1);
    check("lit_restart_q", q_main, 32'hD3C2B1A0);
    step();
    check("lit_restart_done_q", q_main, 32'h5AC2B1A0);
    check("lit_restart_done_active", 32'(act_main), 32'h8);
    check("lit_d0_ch3", 32'(act_d0), 32'h8);
    check("lit_c3_err", 32'(err_c3), 32'h1);
    check("lit_c3_active", 32'(act_c3), 32'h2);

    sel = 2'd0; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("lit_midreset_q", q_main, 32'h0);
    check("lit_midreset_busy", 32'(busy_main), 32'h0);
    check("lit_midreset_c3_err", 32'(err_c3), 32'h0);
    rst = 1'b0;
    step();
    check("lit_after_reset_q", q_main, 32'hD3C2B15A);
    check("lit_after_reset_active", 32'(act_main), 32'h1);

    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      sel      = 2'($urandom_range(0, 3));
      sel_load = ($urandom_range(0, 3) == 0);
      en       = ($urandom_range(0, 4) != 0);
      signal   = 8'($urandom);
      if ($urandom_range(0, 15) == 0) defs = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
